// File: rtl/reflex_core_mc.sv
// reflex_core_mc: multi-channel PD reflex controller.
//   Accepts tagged (z_pos, z_vel) samples on a valid/ready stream and returns
//   u = -(Kp*z + Kd_eff*v) >>> FRAC_BITS clamped to +/-OUT_MAX, four edges later.
//   Each channel keeps a guardian (boosted D gain) with hysteresis and a
//   release hold-off, plus a latched fault after FAULT_N boosted samples in a row.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_valid/s_ready/s_ch           input stream handshake and channel tag
//   z_pos, z_vel                   signed sample
//   kp_gain, kd_gain               shared signed gains
//   vel_threshold, vel_hyst        guardian entry level and exit margin (unsigned)
//   fault_clr                      per-channel clear pulse
//   m_valid/m_ready/m_ch           output stream handshake and channel tag
//   u_out, m_sat, m_guard          result, clamp flag, boosted flag
//   guardian_active, fault         live per-channel state
module reflex_core_mc #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 0,
    parameter int OUT_MAX   = 2000,
    parameter int RELEASE_N = 4,
    parameter int FAULT_N   = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] z_pos,
    input  logic [DATA_W-1:0] z_vel,
    input  logic [GAIN_W-1:0] kp_gain,
    input  logic [GAIN_W-1:0] kd_gain,
    input  logic [DATA_W-1:0] vel_threshold,
    input  logic [DATA_W-1:0] vel_hyst,
    input  logic [N_CH-1:0]   fault_clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic [DATA_W-1:0] u_out,
    output logic              m_sat,
    output logic              m_guard,
    output logic [N_CH-1:0]   guardian_active,
    output logic [N_CH-1:0]   fault
);
    localparam int STAGES = 3;
    localparam int MAG_W  = DATA_W + 1;
    localparam int PP_W   = DATA_W + GAIN_W;
    localparam int PD_W   = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = DATA_W + GAIN_W + 2;
    localparam int CALM_W = $clog2(RELEASE_N + 1);
    localparam int GCNT_W = $clog2(FAULT_N + 1);
    localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'(OUT_MAX);
    localparam logic signed [SUM_W-1:0] U_MIN = -SUM_W'(OUT_MAX);

    // vld_pipe[0..2] = S1..S3, vld_pipe[3] = output register
    logic [STAGES:0] vld_pipe;
    logic            stall, accept;

    assign m_valid = vld_pipe[STAGES];
    assign stall   = vld_pipe[STAGES] && !m_ready;
    assign s_ready = !stall;
    assign accept  = s_valid && s_ready;

    // ---------------- per-channel guardian state ----------------
    logic [N_CH-1:0]   guard_q, fault_q;
    logic [CALM_W-1:0] calm_q [N_CH];
    logic [GCNT_W-1:0] gcnt_q [N_CH];

    assign guardian_active = guard_q;
    assign fault           = fault_q;

    logic              ch_ok;
    logic [CH_W-1:0]   ch_idx;
    logic [MAG_W-1:0]  v_mag, thr_ext, exit_ext;
    logic              cur_guard, cur_fault;
    logic [CALM_W-1:0] cur_calm, calm_nxt;
    logic [GCNT_W-1:0] cur_gcnt, gcnt_nxt;
    logic              boost, guard_nxt, fault_nxt;

    always_comb begin
        ch_ok     = 32'(s_ch) < 32'(N_CH);
        ch_idx    = ch_ok ? s_ch : '0;
        // Sign-extend before negating so -2**(DATA_W-1) has a representable magnitude.
        v_mag     = z_vel[DATA_W-1] ? (MAG_W'(0) - {1'b1, z_vel}) : {1'b0, z_vel};
        thr_ext   = {1'b0, vel_threshold};
        exit_ext  = (vel_threshold > vel_hyst) ? {1'b0, vel_threshold - vel_hyst} : '0;
        cur_guard = guard_q[ch_idx];
        cur_fault = fault_q[ch_idx];
        cur_calm  = calm_q[ch_idx];
        cur_gcnt  = gcnt_q[ch_idx];

        boost     = 1'b0;
        guard_nxt = cur_guard;
        fault_nxt = cur_fault;
        calm_nxt  = cur_calm;
        gcnt_nxt  = cur_gcnt;

        if (ch_ok) begin
            if (!cur_guard) begin
                if (v_mag > thr_ext) begin
                    guard_nxt = 1'b1;
                    calm_nxt  = '0;
                    boost     = 1'b1;
                end
            end else begin
                // The releasing sample itself is still computed boosted.
                boost = 1'b1;
                if (v_mag < exit_ext) begin
                    if (cur_calm == CALM_W'(RELEASE_N - 1)) begin
                        guard_nxt = 1'b0;
                        calm_nxt  = '0;
                    end else begin
                        calm_nxt = cur_calm + 1'b1;
                    end
                end else begin
                    calm_nxt = '0;
                end
            end

            if (boost) begin
                if (cur_gcnt != GCNT_W'(FAULT_N))
                    gcnt_nxt = cur_gcnt + 1'b1;
                if (gcnt_nxt == GCNT_W'(FAULT_N))
                    fault_nxt = 1'b1;
            end else begin
                gcnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            guard_q <= '0;
            fault_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                calm_q[c] <= '0;
                gcnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                // Clear beats a same-cycle sample update on the channel.
                if (fault_clr[c]) begin
                    guard_q[c] <= 1'b0;
                    fault_q[c] <= 1'b0;
                    calm_q[c]  <= '0;
                    gcnt_q[c]  <= '0;
                end else if (accept && ch_ok && (32'(ch_idx) == c)) begin
                    guard_q[c] <= guard_nxt;
                    fault_q[c] <= fault_nxt;
                    calm_q[c]  <= calm_nxt;
                    gcnt_q[c]  <= gcnt_nxt;
                end
            end
        end
    end

    // ---------------- datapath ----------------
    logic [CH_W-1:0]          s1_ch, s2_ch, s3_ch;
    logic signed [DATA_W-1:0] s1_z, s1_v;
    logic signed [GAIN_W-1:0] s1_kp;
    logic signed [GAIN_W:0]   s1_kd;
    logic                     s1_boost, s2_boost, s3_boost;
    logic                     s1_zero, s2_zero, s3_zero;  // fault or bad channel: force u=0
    logic signed [PP_W-1:0]   s2_pp;
    logic signed [PD_W-1:0]   s2_pd;
    logic signed [SUM_W-1:0]  s3_sum, sum_sh;

    assign sum_sh = s3_sum >>> FRAC_BITS;

    always_ff @(posedge clk) begin
        if (!stall) begin
            // S1: capture sample, gains and guardian decision (pre-update fault state)
            s1_ch    <= s_ch;
            s1_z     <= z_pos;
            s1_v     <= z_vel;
            s1_kp    <= kp_gain;
            s1_kd    <= boost ? {kd_gain, 1'b0} : {kd_gain[GAIN_W-1], kd_gain};
            s1_boost <= boost;
            s1_zero  <= !ch_ok || cur_fault;
            // S2: full-precision products
            s2_ch    <= s1_ch;
            s2_pp    <= PP_W'(s1_z) * PP_W'(s1_kp);
            s2_pd    <= PD_W'(s1_v) * PD_W'(s1_kd);
            s2_boost <= s1_boost;
            s2_zero  <= s1_zero;
            // S3: negated sum, wide enough that nothing wraps
            s3_ch    <= s2_ch;
            s3_sum   <= -(SUM_W'(s2_pp) + SUM_W'(s2_pd));
            s3_boost <= s2_boost;
            s3_zero  <= s2_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            m_ch     <= '0;
            u_out    <= '0;
            m_sat    <= 1'b0;
            m_guard  <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            m_ch     <= s3_ch;
            m_guard  <= s3_boost;
            if (s3_zero) begin
                u_out <= '0;
                m_sat <= 1'b0;
            end else if (sum_sh > U_MAX) begin
                u_out <= DATA_W'(OUT_MAX);
                m_sat <= 1'b1;
            end else if (sum_sh < U_MIN) begin
                u_out <= DATA_W'(-OUT_MAX);
                m_sat <= 1'b1;
            end else begin
                u_out <= sum_sh[DATA_W-1:0];
                m_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reflex_core_mc.sv
module tb_reflex_core_mc;
    localparam int N_CH = 4, DATA_W = 16, GAIN_W = 16, FRAC_BITS = 0;
    localparam int OUT_MAX = 2000, RELEASE_N = 4, FAULT_N = 16;

    logic clk = 0, rst, s_valid, s_ready, m_valid, m_ready, m_sat, m_guard;
    logic [1:0] s_ch, m_ch;
    logic signed [DATA_W-1:0] z_pos, z_vel, u_out;
    logic signed [GAIN_W-1:0] kp_gain, kd_gain;
    logic [DATA_W-1:0] vel_threshold, vel_hyst;
    logic [N_CH-1:0] fault_clr, guardian_active, fault;

    always #5 clk = ~clk;

    reflex_core_mc #(.N_CH(N_CH), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_BITS(FRAC_BITS),
                     .OUT_MAX(OUT_MAX), .RELEASE_N(RELEASE_N), .FAULT_N(FAULT_N)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
        .z_pos(z_pos), .z_vel(z_vel), .kp_gain(kp_gain), .kd_gain(kd_gain),
        .vel_threshold(vel_threshold), .vel_hyst(vel_hyst), .fault_clr(fault_clr),
        .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .u_out(u_out), .m_sat(m_sat),
        .m_guard(m_guard), .guardian_active(guardian_active), .fault(fault));

    typedef struct { int ch; int u; bit sat; bit guard; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int cur_kp, cur_kd, cur_thr, cur_hyst;
    bit mdl_act[N_CH], mdl_flt[N_CH];
    int mdl_calm[N_CH], mdl_gcnt[N_CH];
    bit done;

    // Scoreboard: every accepted output transfer is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got ch=%0d u=%0d, required no output", m_ch, u_out);
            end else begin
                mon_e = sb.pop_front();
                if (int'(m_ch) !== mon_e.ch || int'(u_out) !== mon_e.u ||
                    m_sat !== mon_e.sat || m_guard !== mon_e.guard) begin
                    errors++;
                    $display("FAIL result: got ch=%0d u=%0d sat=%0b guard=%0b, required ch=%0d u=%0d sat=%0b guard=%0b",
                             m_ch, u_out, m_sat, m_guard, mon_e.ch, mon_e.u, mon_e.sat, mon_e.guard);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_gains(int kp, int kd, int thr, int hyst);
        cur_kp = kp; cur_kd = kd; cur_thr = thr; cur_hyst = hyst;
        kp_gain = 16'(kp); kd_gain = 16'(kd);
        vel_threshold = 16'(thr); vel_hyst = 16'(hyst);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            mdl_act[c] = 0; mdl_flt[c] = 0; mdl_calm[c] = 0; mdl_gcnt[c] = 0;
        end
    endtask

    // Reference model of one accepted sample: updates channel state, pushes expected result.
    task automatic model_push(int ch, int z, int v);
        exp_t e;
        bit boost = 0, fpre;
        longint av, ex, kde, raw;
        av   = (v < 0) ? -v : v;
        ex   = (cur_thr > cur_hyst) ? cur_thr - cur_hyst : 0;
        fpre = mdl_flt[ch];
        if (!mdl_act[ch]) begin
            if (av > cur_thr) begin mdl_act[ch] = 1; mdl_calm[ch] = 0; boost = 1; end
        end else begin
            boost = 1;
            if (av < ex) begin
                mdl_calm[ch]++;
                if (mdl_calm[ch] == RELEASE_N) begin mdl_act[ch] = 0; mdl_calm[ch] = 0; end
            end else mdl_calm[ch] = 0;
        end
        if (boost) begin
            mdl_gcnt[ch]++;
            if (mdl_gcnt[ch] >= FAULT_N) mdl_flt[ch] = 1;
        end else mdl_gcnt[ch] = 0;
        kde = boost ? 2 * cur_kd : cur_kd;
        raw = -(longint'(cur_kp) * z + kde * v);
        raw = raw >>> FRAC_BITS;
        e.ch = ch; e.guard = boost;
        if (fpre)                 begin e.u = 0;        e.sat = 0; end
        else if (raw > OUT_MAX)   begin e.u = OUT_MAX;  e.sat = 1; end
        else if (raw < -OUT_MAX)  begin e.u = -OUT_MAX; e.sat = 1; end
        else                      begin e.u = int'(raw); e.sat = 0; end
        sb.push_back(e);
    endtask

    task automatic send(int ch, int z, int v);
        int n = 0;
        s_ch = 2'(ch); z_pos = 16'(z); z_vel = 16'(v); s_valid = 1;
        while (!s_ready && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready stayed 0, required 1 within 200 cycles");
        end
        tick();
        s_valid = 0;
        model_push(ch, z, v);
    endtask

    task automatic pulse_clr(int c);
        fault_clr = 4'(1 << c);
        tick();
        fault_clr = '0;
        mdl_act[c] = 0; mdl_flt[c] = 0; mdl_calm[c] = 0; mdl_gcnt[c] = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin tick(); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        checks += 5;
        if (s_ready !== 1'b1)    begin errors++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
        if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %0b required 0", m_valid); end
        if (u_out !== 16'sd0 || m_sat !== 0 || m_guard !== 0 || m_ch !== 0) begin
            errors++; $display("FAIL reset_outputs: got u=%0d sat=%0b guard=%0b ch=%0d required all 0", u_out, m_sat, m_guard, m_ch);
        end
        if (guardian_active !== 4'h0) begin errors++; $display("FAIL reset_guardian: got %b required 0000", guardian_active); end
        if (fault !== 4'h0)      begin errors++; $display("FAIL reset_fault: got %b required 0000", fault); end
        rst = 0;
        model_reset();
        tick();
    endtask

    task automatic test_basic();
        set_gains(10, 5, 1000, 200);
        send(0, 100, 20);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL latency_early: m_valid=%0b at edge N+%0d, required 0", m_valid, k); end
            tick();
        end
        checks++;
        if (m_valid !== 1'b1 || u_out !== -16'sd1100 || m_sat !== 0 || m_guard !== 0) begin
            errors++;
            $display("FAIL latency_n3: got valid=%0b u=%0d sat=%0b guard=%0b required valid=1 u=-1100 sat=0 guard=0",
                     m_valid, u_out, m_sat, m_guard);
        end
        drain();
    endtask

    task automatic test_saturation();
        set_gains(10, 5, 1000, 200);
        send(1, 0, 1500);
        checks++;
        if (guardian_active[1] !== 1'b1) begin errors++; $display("FAIL guard_entry_ch1: got %0b required 1", guardian_active[1]); end
        set_gains(1, 5, 1000, 200);
        send(0, -32768, 0);          // -(1*-32768) -> +2000 clamped
        set_gains(-1, 5, 1000, 200);
        send(0, -32768, 0);          // -(-1*-32768) -> -2000 clamped
        send(0, 0, -32768);          // most negative velocity enters guardian
        checks++;
        if (guardian_active[0] !== 1'b1) begin errors++; $display("FAIL guard_entry_minv: got %0b required 1", guardian_active[0]); end
        drain();
    endtask

    task automatic test_hysteresis();
        set_gains(10, 5, 1000, 200);
        send(2, 0, 1500);
        for (int k = 0; k < 4; k++) begin
            send(2, 0, 900);
            checks++;
            if (guardian_active[2] !== 1'b1) begin errors++; $display("FAIL hyst_hold_%0d: got %0b required 1", k, guardian_active[2]); end
        end
        for (int k = 0; k < 4; k++) begin
            send(2, 0, 700);
            checks++;
            if (guardian_active[2] !== (k < 3)) begin
                errors++; $display("FAIL hyst_release_%0d: got %0b required %0b", k, guardian_active[2], k < 3);
            end
        end
        send(2, 0, 1000);
        checks++;
        if (guardian_active[2] !== 1'b0) begin errors++; $display("FAIL thr_equal_no_entry: got %0b required 0", guardian_active[2]); end
        drain();
    endtask

    task automatic test_fault();
        set_gains(10, 5, 1000, 200);
        for (int k = 0; k < FAULT_N; k++) begin
            send(3, 0, 5000);
            checks++;
            if (fault[3] !== (k == FAULT_N - 1)) begin
                errors++; $display("FAIL fault_count_%0d: got %0b required %0b", k, fault[3], k == FAULT_N - 1);
            end
        end
        send(3, 0, 5000);            // faulted channel: u=0
        send(0, 10, 0);              // other channel unaffected
        drain();
        pulse_clr(3);
        checks++;
        if (fault[3] !== 1'b0 || guardian_active[3] !== 1'b0) begin
            errors++; $display("FAIL fault_clr: got fault=%0b guard=%0b required 0 0", fault[3], guardian_active[3]);
        end
        send(3, 5, 0);
        drain();
    endtask

    task automatic test_stall();
        set_gains(10, 5, 1000, 200);
        m_ready = 0;
        send(0, 1, 0);
        send(1, 2, 0);
        send(2, 3, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || int'(u_out) !== sb[0].u || int'(m_ch) !== sb[0].ch) begin
                errors++;
                $display("FAIL stall_hold_%0d: got s_ready=%0b valid=%0b ch=%0d u=%0d required 0 1 %0d %0d",
                         k, s_ready, m_valid, m_ch, u_out, sb[0].ch, sb[0].u);
            end
            tick();
        end
        m_ready = 1;
        drain();
    endtask

    task automatic test_back_to_back();
        set_gains(7, 3, 1000, 300);
        done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(int'($urandom_range(0, 3)), int'($urandom_range(0, 600)) - 300,
                         int'($urandom_range(0, 3000)) - 1500);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1;
        drain();
    endtask

    task automatic test_reset_midstream();
        set_gains(10, 5, 1000, 200);
        send(0, 5, 0);
        send(1, 6, 0);
        rst = 1;
        tick();
        rst = 0;
        sb.delete();
        model_reset();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_midstream_%0d: m_valid=%0b required 0", k, m_valid); end
            tick();
        end
        checks++;
        if (guardian_active !== 4'h0 || fault !== 4'h0) begin
            errors++; $display("FAIL rst_midstream_state: got guard=%b fault=%b required 0000 0000", guardian_active, fault);
        end
    endtask

    initial begin
        rst = 1; s_valid = 0; s_ch = 0; z_pos = 0; z_vel = 0; m_ready = 1; fault_clr = '0;
        set_gains(10, 5, 1000, 200);
        @(posedge clk); #2;
        test_reset();
        test_basic();
        test_saturation();
        test_hysteresis();
        test_fault();
        test_stall();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
